// File: rtl/decoder.sv
// Registered binary-to-one-hot decoder: out[k] is set one cycle after in == k.
// Used as a select/enable generator feeding wide fan-out logic.
module decoder #(
   parameter int ENCODE_WIDTH = 4,
   parameter int DECODE_WIDTH = 2 ** ENCODE_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ENCODE_WIDTH-1:0] in,
   output logic [DECODE_WIDTH-1:0] out
);

   // DECODE_WIDTH exists only so callers can read the output width; it must track ENCODE_WIDTH.
   if (ENCODE_WIDTH < 1) begin : g_bad_encode_width
      $error("decoder: ENCODE_WIDTH must be >= 1");
   end
   if (DECODE_WIDTH != 2 ** ENCODE_WIDTH) begin : g_bad_decode_width
      $error("decoder: DECODE_WIDTH must equal 2**ENCODE_WIDTH");
   end

   logic [DECODE_WIDTH-1:0] next_out;

   for (genvar k = 0; k < DECODE_WIDTH; k++) begin : g_cmp
      assign next_out[k] = (in == ENCODE_WIDTH'(k));
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) out <= '0;
      else     out <= next_out;
   end

`ifndef SYNTHESIS
   a_in_known : assert property (@(posedge clk) !rst |-> !$isunknown(in))
      else $error("decoder: in is X/Z outside reset");
   a_out_onehot : assert property (@(posedge clk) !rst |=> $onehot(out))
      else $error("decoder: out is not one-hot after a decode edge");
`endif

endmodule

// File: tb/tb_decoder.sv
// Directed bench for decoder at ENCODE_WIDTH = 4, 1 and 6 sharing one clock and reset.
module tb_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  in4 = 4'h9;
   logic [15:0] out4;
   logic        in1 = 1'b0;
   logic [1:0]  out1;
   logic [5:0]  in6 = 6'd0;
   logic [63:0] out6;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   decoder #(.ENCODE_WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .in(in4), .out(out4));
   decoder #(.ENCODE_WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .in(in1), .out(out1));
   decoder #(.ENCODE_WIDTH(6)) u_dut6 (.clk(clk), .rst(rst), .in(in6), .out(out6));

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance past the next rising edge so outputs are sampled away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] exp4;

      // Reset held for three edges with a nonzero index presented.
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("reset4_%0d", i), out4, 16'h0000);
      end
      check("reset1", out1, 2'b00);
      check("reset6", out6, 64'h0);

      // Exhaustive sweep of the 4-bit index.
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         in4 = 4'(i);
         tick();
         exp4 = 16'h0001 << i;
         check($sformatf("sweep_%0d", i), out4, exp4);
         check($sformatf("sweep_onehot_%0d", i), 64'($onehot(out4)), 64'd1);
      end

      // Wrap-around from all-ones back to zero.
      in4 = 4'hf;
      tick();
      check("wrap_hi", out4, 16'h8000);
      in4 = 4'h0;
      tick();
      check("wrap_lo", out4, 16'h0001);

      // Mid-cycle input change must not reach the output before the edge.
      in4 = 4'd3;
      tick();
      check("lat_before", out4, 16'h0008);
      #2 in4 = 4'd12;
      #1 check("lat_mid", out4, 16'h0008);
      tick();
      check("lat_after", out4, 16'h1000);

      // Reset asserted mid-sweep wins over the index on the same edge.
      for (int i = 0; i < 7; i++) begin
         in4 = 4'(i);
         tick();
      end
      check("mid_pre", out4, 16'h0040);
      in4 = 4'd7;
      rst = 1'b1;
      tick();
      check("mid_rst", out4, 16'h0000);
      tick();
      check("mid_rst_hold", out4, 16'h0000);
      rst = 1'b0;
      in4 = 4'd2;
      tick();
      check("mid_release", out4, 16'h0004);

      // Width corners.
      in1 = 1'b1;
      in6 = 6'd63;
      tick();
      check("w1_one", out1, 2'b10);
      check("w6_top", out6, 64'h8000_0000_0000_0000);
      in1 = 1'b0;
      in6 = 6'd0;
      tick();
      check("w1_zero", out1, 2'b01);
      check("w6_zero", out6, 64'h0000_0000_0000_0001);
      in6 = 6'd37;
      tick();
      check("w6_mid", out6, 64'h0000_0020_0000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
